// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams and serial transmitter handshake shared by
// uart_tx_arbiter and whatever drives it.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 stall_abort;

  modport master (
    output req_valid,
    output req_data,
    output req_last,
    output tx_busy,
    input  req_ready,
    input  grant,
    input  tx_start,
    input  tx_data,
    input  stall_abort
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_last,
    input  tx_busy,
    output req_ready,
    output grant,
    output tx_start,
    output tx_data,
    output stall_abort
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART transmitter among NUM_REQ
// byte streams. Define UART_ARB_HEADER_EN to prefix each packet with {4'hA, g}.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int STALL_LIMIT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = IW + 1;
  localparam int CW = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT + 1) : 1;
  localparam logic [CW-1:0] STALL_LAST = CW'(STALL_LIMIT - 1);

`ifdef UART_ARB_HEADER_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_e;
`endif

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic               last_q, last_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               stall_abort_q, stall_abort_d;
  logic [CW-1:0]      stall_cnt_q, stall_cnt_d;
  logic [NUM_REQ-1:0] req_ready;

  logic [2*NUM_REQ-1:0] dbl_vld;
  logic [NUM_REQ-1:0]   rot_vld;
  logic [IW-1:0]        pick_k;
  logic [PW-1:0]        pick_sum;
  logic [IW-1:0]        pick_idx;
  logic                 pick_vld;

  // Rotate valids so bit 0 is the requester just after the last owner.
  always_comb begin
    dbl_vld  = {bus.req_valid, bus.req_valid};
    rot_vld  = NUM_REQ'(dbl_vld >> ({1'b0, ptr_q} + PW'(1)));
    pick_vld = |bus.req_valid;
    pick_k   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_vld[k]) pick_k = IW'(k);
    end
    pick_sum = {1'b0, ptr_q} + PW'(1) + {1'b0, pick_k};
    if (pick_sum >= PW'(NUM_REQ)) begin
      pick_sum = pick_sum - PW'(NUM_REQ);
    end
    pick_idx = pick_sum[IW-1:0];
  end

  logic       g_valid;
  logic       g_last;
  logic [7:0] g_data;

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        g_valid = bus.req_valid[i];
        g_last  = bus.req_last[i];
        g_data  = bus.req_data[8*i +: 8];
      end
    end
  end

`ifdef UART_ARB_HEADER_EN
  logic [7:0] hdr_byte;
  assign hdr_byte = {4'hA, 4'(gidx_q)};
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    ptr_d         = ptr_q;
    last_d        = last_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    stall_abort_d = 1'b0;
    stall_cnt_d   = '0;
    req_ready     = '0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          gidx_d            = pick_idx;
`ifdef UART_ARB_HEADER_EN
          state_d           = S_HDR;
`else
          state_d           = S_LOAD;
`endif
        end
      end
`ifdef UART_ARB_HEADER_EN
      S_HDR: begin
        if (!bus.tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = hdr_byte;
          last_d     = 1'b0;
          state_d    = S_WAIT_BUSY;
        end
      end
`endif
      S_LOAD: begin
        stall_cnt_d = stall_cnt_q;
        if (!g_valid) begin
          if (STALL_LIMIT != 0 && stall_cnt_q == STALL_LAST) begin
            stall_abort_d = 1'b1;
            stall_cnt_d   = '0;
            ptr_d         = gidx_q;
            grant_d       = '0;
            state_d       = S_IDLE;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end else if (!bus.tx_busy) begin
          req_ready   = grant_q;
          tx_start_d  = 1'b1;
          tx_data_d   = g_data;
          last_d      = g_last;
          stall_cnt_d = '0;
          state_d     = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (bus.tx_busy) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          if (last_q) begin
            ptr_d   = gidx_q;
            grant_d = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      grant_q       <= '0;
      gidx_q        <= '0;
      ptr_q         <= IW'(NUM_REQ - 1);
      last_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      stall_abort_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      ptr_q         <= ptr_d;
      last_q        <= last_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      stall_abort_q <= stall_abort_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.grant       = grant_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.stall_abort = stall_abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues feed the DUT and a
// scoreboard of expected (owner, byte) pairs is checked on every tx_start.
module tb_uart_tx_arbiter;

  localparam int N = 4;

`ifdef UART_ARB_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ    (N),
    .STALL_LIMIT(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises the cycle after start, stays up 10 cycles.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (bus.tx_start === 1'b1) busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = (busy_cnt != 0);

  int checks = 0;
  int passed = 0;

  logic [8:0]  rq [N][$];
  logic [11:0] sb [$];

  int cyc = 0;
  int aborts = 0;
  int abort_cyc = 0;
  logic [N-1:0] abort_grant = '0;
  int fall_cyc = 0;
  int first_fall_cyc = 0;
  int first_start_cyc = 0;
  int bad_start = 0;
  int ready_err = 0;
  int accepts = 0;
  logic prev_busy = 1'b0;

  logic [11:0]  mon_e;
  logic [N-1:0] mon_g;

  always @(negedge clk) begin
    if (bus.tx_start === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        $display("FAIL tx_stream: unexpected start data=%02h grant=%b",
                 bus.tx_data, bus.grant);
      end else begin
        mon_e = sb.pop_front();
        mon_g = '0;
        mon_g[mon_e[9:8]] = 1'b1;
        if (bus.tx_data !== mon_e[7:0] || bus.grant !== mon_g)
          $display("FAIL tx_stream: got data=%02h grant=%b want data=%02h grant=%b",
                   bus.tx_data, bus.grant, mon_e[7:0], mon_g);
        else passed++;
      end
    end
  end

  task automatic present();
    logic [N-1:0]   v;
    logic [N-1:0]   l;
    logic [8*N-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0) begin
        v[i]       = 1'b1;
        l[i]       = rq[i][0][8];
        d[8*i +: 8] = rq[i][0][7:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    cyc++;
    if (bus.stall_abort === 1'b1) begin
      aborts++;
      abort_cyc   = cyc;
      abort_grant = bus.grant;
    end
    if (prev_busy && !bus.tx_busy) begin
      fall_cyc = cyc;
      if (first_fall_cyc == 0) first_fall_cyc = cyc;
    end
    if (bus.tx_start === 1'b1) begin
      if (first_start_cyc == 0) first_start_cyc = cyc;
      if (prev_busy) bad_start++;
    end
    prev_busy = bus.tx_busy;
    if ((bus.req_ready & ~bus.grant) != '0) ready_err++;
    acc = bus.req_ready & bus.req_valid;
    accepts += $countones(acc);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
    end
    present();
  endtask

  task automatic drive(input string name, input int max_cyc);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    present();
    while (!done && n < max_cyc) begin
      step();
      n++;
      done = (sb.size() == 0) && (bus.grant == '0) && !bus.tx_busy;
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() > 0) done = 1'b0;
      end
    end
    checks++;
    if (!done)
      $display("FAIL %s: got timeout after %0d cycles with %0d bytes pending, want drained",
               name, n, sb.size());
    else passed++;
  endtask

  task automatic feed(input int g, input logic [7:0] d, input bit last);
    rq[g].push_back({last, d});
  endtask

  task automatic want(input int g, input logic [7:0] d, input bit first);
    if (first && HDR) sb.push_back({4'(g), 4'hA, 4'(g)});
    sb.push_back({4'(g), d});
  endtask

  task automatic test_reset();
    logic [17:0] obs;
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.req_last  = '1;
    bus.req_data  = 32'hA5C3_5A3C;
    repeat (2) begin
      @(negedge clk);
      obs = {bus.grant, bus.req_ready, bus.tx_start, bus.stall_abort, bus.tx_data};
      checks++;
      if (obs !== '0)
        $display("FAIL reset_outputs: got %h want 0", obs);
      else passed++;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    present();
    step();
    checks++;
    if (bus.grant !== '0)
      $display("FAIL reset_idle_grant: got %b want 0000", bus.grant);
    else passed++;
  endtask

  task automatic test_round_robin();
    int c0;
    for (int k = 0; k < 2; k++) begin
      feed(1, 8'h11, 1'b1);
      feed(3, 8'h33, 1'b1);
      want(1, 8'h11, 1'b1);
      want(3, 8'h33, 1'b1);
    end
    c0 = cyc;
    first_start_cyc = 0;
    drive("round_robin", 400);
`ifndef UART_ARB_HEADER_EN
    checks++;
    if (first_start_cyc - c0 - 1 !== 2)
      $display("FAIL start_latency: got %0d want 2", first_start_cyc - c0 - 1);
    else passed++;
`endif
  endtask

  task automatic test_packet_lock();
    int a0;
    a0 = accepts;
    feed(0, 8'hC0, 1'b0);
    feed(0, 8'hC1, 1'b0);
    feed(0, 8'hC2, 1'b1);
    feed(1, 8'hD0, 1'b1);
    want(0, 8'hC0, 1'b1);
    want(0, 8'hC1, 1'b0);
    want(0, 8'hC2, 1'b0);
    want(1, 8'hD0, 1'b1);
    drive("packet_lock", 400);
    checks++;
    if (accepts - a0 !== 4)
      $display("FAIL lock_accepts: got %0d want 4", accepts - a0);
    else passed++;
  endtask

  task automatic test_stall();
    aborts = 0;
    feed(3, 8'h7E, 1'b0);
    want(3, 8'h7E, 1'b1);
    drive("stall", 400);
    step();
    checks++;
    if (aborts !== 1)
      $display("FAIL stall_pulses: got %0d want 1", aborts);
    else passed++;
    checks++;
    if (abort_cyc - fall_cyc !== 9)
      $display("FAIL stall_timing: got %0d want 9", abort_cyc - fall_cyc);
    else passed++;
    checks++;
    if (abort_grant !== '0)
      $display("FAIL stall_grant: got %b want 0000", abort_grant);
    else passed++;
    // Owner pointer sits at requester 3, so requester 0 wins next.
    feed(2, 8'h55, 1'b1);
    feed(0, 8'h44, 1'b1);
    want(0, 8'h44, 1'b1);
    want(2, 8'h55, 1'b1);
    drive("after_stall", 400);
  endtask

`ifdef UART_ARB_HEADER_EN
  task automatic test_header();
    int a0;
    a0 = accepts;
    feed(2, 8'h5A, 1'b1);
    want(2, 8'h5A, 1'b1);
    drive("header", 400);
    checks++;
    if (accepts - a0 !== 1)
      $display("FAIL header_ready_pulses: got %0d want 1", accepts - a0);
    else passed++;
  endtask
`endif

  task automatic test_reset_midframe();
    int n;
    feed(2, 8'h66, 1'b0);
    feed(2, 8'h67, 1'b1);
    want(2, 8'h66, 1'b1);
    present();
    n = 0;
    while (!bus.tx_busy && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (!bus.tx_busy)
      $display("FAIL midframe_busy: got busy=0 want 1 within 100 cycles");
    else passed++;
    step();
    step();
    rst_n = 1'b0;
    rq[2].delete();
    // The abandoned packet's remaining bytes will never be sent.
    sb.delete();
    present();
    step();
    checks++;
    if (bus.grant !== '0 || bus.tx_start !== 1'b0)
      $display("FAIL midframe_reset: got grant=%b start=%b want 0000/0",
               bus.grant, bus.tx_start);
    else passed++;
    rst_n           = 1'b1;
    bad_start       = 0;
    first_fall_cyc  = 0;
    first_start_cyc = 0;
    feed(1, 8'h77, 1'b1);
    want(1, 8'h77, 1'b1);
    drive("midframe_resume", 400);
    checks++;
    if (bad_start !== 0)
      $display("FAIL midframe_start_while_busy: got %0d want 0", bad_start);
    else passed++;
    checks++;
    if (first_fall_cyc == 0 || first_start_cyc <= first_fall_cyc)
      $display("FAIL midframe_order: got start=%0d fall=%0d want start after fall",
               first_start_cyc, first_fall_cyc);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_stall();
`ifdef UART_ARB_HEADER_EN
    test_header();
`endif
    test_reset_midframe();
    checks++;
    if (ready_err !== 0)
      $display("FAIL ready_outside_grant: got %0d want 0", ready_err);
    else passed++;
    checks++;
    if (sb.size() !== 0)
      $display("FAIL scoreboard_leftover: got %0d want 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
